// File: rtl/add_scb_pkg.sv
// Shared types and defaults for the adder result scoreboard.
// scb_triple_t documents the {a, b, sum} layout at the default width.
package add_scb_pkg;

    localparam int SCB_WIDTH   = 8;
    localparam int SCB_DEPTH   = 4;
    localparam int SCB_CNT_W   = 16;
    localparam int SCB_NUM_TXN = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } scb_state_e;

    typedef struct packed {
        logic [SCB_WIDTH-1:0] a;
        logic [SCB_WIDTH-1:0] b;
        logic [SCB_WIDTH-1:0] sum;
    } scb_triple_t;

endpackage

// File: rtl/add_scb_fifo.sv
// Synchronous FIFO with a ptr+1-bit occupancy count; head is the oldest entry.
// Push when full and pop when empty are ignored.
module add_scb_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push_ok, pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/add_result_scoreboard.sv
// Checks {a, b, sum} triples from the adder stage: sum must equal (a+b) mod 2^WIDTH.
// Define ADD_SCB_FIRST_FAIL_CAPTURE_EN to add the first-failure capture ports.
module add_result_scoreboard
    import add_scb_pkg::*;
#(
    parameter int WIDTH   = SCB_WIDTH,
    parameter int DEPTH   = SCB_DEPTH,
    parameter int CNT_W   = SCB_CNT_W,
    parameter int NUM_TXN = SCB_NUM_TXN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic             done
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_sum,
    output logic [WIDTH-1:0] fail_exp
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } trip_t;

    scb_state_e       state, state_nxt;
    trip_t            in_trip, head;
    logic             fifo_full, fifo_empty, push, pop;
    logic [CNT_W-1:0] chk_cnt, chk_inc;
    logic [WIDTH-1:0] exp_q, sum_q;
    logic             match;
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] a_q, b_q;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_trip  = '{a: in_a, b: in_b, sum: in_sum};
    assign done     = (state == DONE);
    // No bypass: a pop in the same cycle does not free a slot for this push.
    assign in_ready = !fifo_full && !done && !rst;
    assign push     = in_valid && in_ready;
    assign chk_inc  = sat_inc(chk_cnt);
    assign match    = (sum_q == exp_q);

    add_scb_fifo #(
        .DW    ($bits(trip_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_trip),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE:   if (!fifo_empty) state_nxt = CHECK;
            CHECK: begin
                pop       = 1'b1;
                state_nxt = UPDATE;
            end
            UPDATE: begin
                if (chk_inc == CNT_W'(NUM_TXN)) state_nxt = DONE;
                else if (!fifo_empty)           state_nxt = CHECK;
                else                            state_nxt = IDLE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pass_cnt <= '0;
            fail_cnt <= '0;
            chk_cnt  <= '0;
            err      <= 1'b0;
            exp_q    <= '0;
            sum_q    <= '0;
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
            a_q      <= '0;
            b_q      <= '0;
            fail_a   <= '0;
            fail_b   <= '0;
            fail_sum <= '0;
            fail_exp <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == CHECK) begin
                // Carry out of the add is discarded by the WIDTH-bit target.
                exp_q <= head.a + head.b;
                sum_q <= head.sum;
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
                a_q   <= head.a;
                b_q   <= head.b;
`endif
            end
            if (state == UPDATE) begin
                chk_cnt <= chk_inc;
                if (match) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                    err      <= 1'b1;
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
                    if (!err) begin
                        fail_a   <= a_q;
                        fail_b   <= b_q;
                        fail_sum <= sum_q;
                        fail_exp <= exp_q;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_add_result_scoreboard.sv
// Directed bench for add_result_scoreboard: vector table plus back-pressure,
// completion and mid-operation reset sequences.
module tb_add_result_scoreboard;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int NUM_TXN = 25;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0, in_b = '0, in_sum = '0;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic             err, done;
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] fail_a, fail_b, fail_sum, fail_exp;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_result_scoreboard #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .NUM_TXN(NUM_TXN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sum   (in_sum),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .err      (err),
        .done     (done)
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
        ,
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .fail_sum (fail_sum),
        .fail_exp (fail_exp)
`endif
    );

    typedef struct {
        int a, b, sum;
        int exp_pass, exp_fail, exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reset for one cycle while presenting a triple that must be dropped.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_sum = 8'd2;
        #1 chk("ready_in_reset", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ready_after_reset", int'(in_ready), 1);
        chk("pass_after_reset", int'(pass_cnt), 0);
        chk("fail_after_reset", int'(fail_cnt), 0);
        chk("err_after_reset", int'(err), 0);
        chk("done_after_reset", int'(done), 0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int a, input int b, input int s, output bit ok);
        in_valid = 1'b1;
        in_a = a[WIDTH-1:0]; in_b = b[WIDTH-1:0]; in_sum = s[WIDTH-1:0];
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int accepted, first_stall, cyc;
        logic [CNT_W-1:0] p_snap, f_snap;

        tbl[0] = '{15,  60,  75,  1, 0, 0};
        tbl[1] = '{200, 100, 44,  2, 0, 0};
        tbl[2] = '{12,  70,  83,  2, 1, 1};
        tbl[3] = '{13,  70,  83,  3, 1, 1};
        tbl[4] = '{255, 1,   0,   4, 1, 1};
        tbl[5] = '{0,   0,   0,   5, 1, 1};
        tbl[6] = '{128, 128, 0,   6, 1, 1};
        tbl[7] = '{255, 255, 253, 6, 2, 1};

        repeat (2) @(negedge clk);
        do_reset();

        // Single-triple vectors, each drained before the next.
        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = tbl[i].a[WIDTH-1:0]; in_b = tbl[i].b[WIDTH-1:0]; in_sum = tbl[i].sum[WIDTH-1:0];
            chk("ready_idle", int'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            if (i == 0) chk("latency_k2_pass", int'(pass_cnt), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_pass", i), int'(pass_cnt), tbl[i].exp_pass);
            chk($sformatf("vec%0d_fail", i), int'(fail_cnt), tbl[i].exp_fail);
            chk($sformatf("vec%0d_err", i), int'(err), tbl[i].exp_err);
`ifdef ADD_SCB_FIRST_FAIL_CAPTURE_EN
            if (i >= 2) begin
                chk("cap_a", int'(fail_a), 12);
                chk("cap_b", int'(fail_b), 70);
                chk("cap_sum", int'(fail_sum), 83);
                chk("cap_exp", int'(fail_exp), 82);
            end
`endif
        end

        // Back-pressure: valid held every cycle with correct sums.
        do_reset();
        accepted = 0;
        first_stall = -1;
        cyc = 0;
        @(negedge clk);
        while (accepted < 12 && cyc < 200) begin
            in_valid = 1'b1;
            in_a = 8'(accepted); in_b = 8'(2 * accepted + 100); in_sum = 8'(3 * accepted + 100);
            if (in_ready) accepted++;
            else if (first_stall < 0) first_stall = accepted;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", accepted, 12);
        chk("bp_stalled", int'(first_stall >= DEPTH + 1 && first_stall <= DEPTH + 2), 1);
        repeat (40) @(negedge clk);
        chk("bp_pass", int'(pass_cnt), 12);
        chk("bp_fail", int'(fail_cnt), 0);

        // Completion after NUM_TXN correct triples.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NUM_TXN; i++) begin
            send(i * 7, i * 11 + 3, (i * 18 + 3) % 256, ok);
            if (!ok) chk($sformatf("cmp_send%0d", i), 0, 1);
        end
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("cmp_done", int'(done), 1);
        chk("cmp_pass_at_done", int'(pass_cnt), NUM_TXN);
        chk("cmp_fail", int'(fail_cnt), 0);
        chk("cmp_ready_low", int'(in_ready), 0);
        p_snap = pass_cnt;
        f_snap = fail_cnt;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2; in_sum = 8'd9;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("cmp_pass_hold", int'(pass_cnt), int'(p_snap));
        chk("cmp_fail_hold", int'(fail_cnt), int'(f_snap));
        chk("cmp_err_hold", int'(err), 0);
        chk("cmp_done_hold", int'(done), 1);
        chk("cmp_ready_hold", int'(in_ready), 0);

        // Reset with three triples queued: nothing may be counted.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 8'(i + 1); in_b = 8'(i + 2); in_sum = 8'(2 * i + 3);
            chk($sformatf("mid_ready%0d", i), int'(in_ready), 1);
            @(negedge clk);
        end
        do_reset();
        repeat (12) @(negedge clk);
        chk("mid_pass", int'(pass_cnt), 0);
        chk("mid_fail", int'(fail_cnt), 0);
        chk("mid_err", int'(err), 0);
        chk("mid_done", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
